// File: rtl/modport_fifo_pkg.sv
// modport_fifo_pkg
//   Shared defaults and types for the modport_fifo slice.
//   DATA_W / DEPTH      : default word width and number of entries
//   ALM_*_TH            : default almost-full / almost-empty thresholds
//   PTR_W               : pointer width derived from DEPTH
//   ptr_t / cnt_t       : pointer and occupancy-count types (count is one bit wider)
//   data_t              : stored word type
package modport_fifo_pkg;

  localparam int DATA_W       = 128;
  localparam int DEPTH        = 16;
  localparam int ALM_FULL_TH  = 14;
  localparam int ALM_EMPTY_TH = 2;
  localparam int PTR_W        = $clog2(DEPTH);

  typedef logic [PTR_W-1:0]  ptr_t;
  typedef logic [PTR_W:0]    cnt_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/modport_fifo_if.sv
// modport_fifo_if
//   Producer/consumer bus of the FIFO.
//   master : drives i_wren, i_wrdata, i_rden; observes data and status
//   slave  : the FIFO side, drives o_rddata and the status flags
//   With MODPORT_FIFO_ERR_EN defined the bus also carries the sticky
//   o_ovf / o_udf error flags.
interface modport_fifo_if #(
  parameter int DATA_W = modport_fifo_pkg::DATA_W
);
  import modport_fifo_pkg::*;

  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;
`ifdef MODPORT_FIFO_ERR_EN
  logic              o_ovf;
  logic              o_udf;
`endif

  modport master (
    output i_wren, i_wrdata, i_rden,
`ifdef MODPORT_FIFO_ERR_EN
    input  o_ovf, o_udf,
`endif
    input  o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden,
`ifdef MODPORT_FIFO_ERR_EN
    output o_ovf, o_udf,
`endif
    output o_rddata, o_full, o_empty, o_alm_full, o_alm_empty
  );

endinterface

// File: rtl/modport_fifo_mem.sv
// modport_fifo_mem
//   Simple dual-port storage: one synchronous write port, one synchronous
//   read port with read enable. The read register holds when rd_en is low.
//   clk, rstn         : clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr/rd_data : read port, rd_data registered
module modport_fifo_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  import modport_fifo_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/modport_fifo.sv
// modport_fifo
//   Single-clock FIFO with full/empty and programmable almost-full /
//   almost-empty status. Read data is registered (1-cycle latency, no
//   fall-through). Optional sticky overflow/underflow flags are built when
//   MODPORT_FIFO_ERR_EN is defined.
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : modport_fifo_if.slave (write/read requests, read data, status)
module modport_fifo #(
  parameter int DATA_W       = modport_fifo_pkg::DATA_W,
  parameter int DEPTH        = modport_fifo_pkg::DEPTH,
  parameter int ALM_FULL_TH  = modport_fifo_pkg::ALM_FULL_TH,
  parameter int ALM_EMPTY_TH = modport_fifo_pkg::ALM_EMPTY_TH
) (
  input  logic           clk,
  input  logic           rstn,
  modport_fifo_if.slave  bus
);
  import modport_fifo_pkg::*;

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_AF   = (AW+1)'(ALM_FULL_TH);
  localparam logic [AW:0] CNT_AE   = (AW+1)'(ALM_EMPTY_TH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, empty;
  logic          wr_acc, rd_acc;

  assign full   = (cnt == CNT_FULL);
  assign empty  = (cnt == '0);
  // Both requests qualify against the flags as they stood before the edge.
  assign wr_acc = bus.i_wren && !full;
  assign rd_acc = bus.i_rden && !empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Write gated by rstn so reset overrides a concurrent write into the array.
  modport_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_acc && rstn),
    .wr_addr (wr_ptr),
    .wr_data (bus.i_wrdata),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.o_rddata)
  );

  assign bus.o_full      = full;
  assign bus.o_empty     = empty;
  assign bus.o_alm_full  = (cnt >= CNT_AF);
  assign bus.o_alm_empty = (cnt <= CNT_AE);

`ifdef MODPORT_FIFO_ERR_EN
  logic ovf, udf;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (bus.i_wren && full)  ovf <= 1'b1;
      if (bus.i_rden && empty) udf <= 1'b1;
    end
  end

  assign bus.o_ovf = ovf;
  assign bus.o_udf = udf;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// tb_modport_fifo
//   Randomized and directed stimulus against a queue-based reference model.
//   Inputs change at the falling edge; outputs are checked at the next
//   falling edge, well away from the sampling edge.
module tb_modport_fifo;
  import modport_fifo_pkg::*;

  logic clk;
  logic rstn;

  modport_fifo_if bus ();

  modport_fifo dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  data_t q[$];
  data_t exp_rd;
  logic  exp_ovf;
  logic  exp_udf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic data_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: drive, let the edge happen, advance the model, check outputs.
  task automatic step(input logic r, input logic we, input data_t wd, input logic re);
    bit was_full, was_empty;
    rstn         = r;
    bus.i_wren   = we;
    bus.i_wrdata = wd;
    bus.i_rden   = re;
    @(posedge clk);
    if (!r) begin
      q.delete();
      exp_rd  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (we && was_full)  exp_ovf = 1'b1;
      if (re && was_empty) exp_udf = 1'b1;
      if (re && !was_empty) exp_rd = q.pop_front();
      if (we && !was_full)  q.push_back(wd);
    end
    @(negedge clk);
    check("rddata",    bus.o_rddata,    exp_rd);
    check("full",      bus.o_full,      q.size() == DEPTH);
    check("empty",     bus.o_empty,     q.size() == 0);
    check("alm_full",  bus.o_alm_full,  q.size() >= ALM_FULL_TH);
    check("alm_empty", bus.o_alm_empty, q.size() <= ALM_EMPTY_TH);
`ifdef MODPORT_FIFO_ERR_EN
    check("ovf", bus.o_ovf, exp_ovf);
    check("udf", bus.o_udf, exp_udf);
`endif
  endtask

  task automatic wr(input data_t d);
    step(1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic rd();
    step(1'b1, 1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, rnd_word(), 1'b1);
    step(1'b0, 1'b1, rnd_word(), 1'b0);
  endtask

  initial begin
    data_t last;
    rstn = 1'b0; bus.i_wren = 1'b1; bus.i_wrdata = 128'hAA; bus.i_rden = 1'b0;
    exp_rd = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

    // Reset with write held, then confirm nothing was captured.
    do_reset();
    idle();
    rd();

    // Ordered fill and drain 0x1..0x10.
    for (int i = 1; i <= 16; i++) wr(data_t'(i));
    check("full_after_16", bus.o_full, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      rd();
      check("order", bus.o_rddata, data_t'(i));
    end
    check("empty_after_16", bus.o_empty, 1'b1);

    // Overflow: 0xDEAD must be dropped.
    for (int i = 0; i < 16; i++) wr(rnd_word());
    wr(128'hDEAD);
    for (int i = 0; i < 16; i++) begin
      rd();
      if (bus.o_rddata === 128'hDEAD) check("dead_seen", bus.o_rddata, '0);
    end

    // Underflow: read data holds.
    last = bus.o_rddata;
    rd(); rd();
    check("udf_hold", bus.o_rddata, last);

    // Threshold walk up and down (flags checked every step).
    do_reset();
    for (int i = 0; i < 16; i++) wr(rnd_word());
    for (int i = 0; i < 16; i++) rd();

    // Simultaneous at count 8 across pointer wrap.
    for (int i = 0; i < 8; i++) wr(rnd_word());
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rnd_word(), 1'b1);
    for (int i = 0; i < 8; i++) rd();

    // Simultaneous at full: read wins, write dropped.
    for (int i = 0; i < 16; i++) wr(rnd_word());
    step(1'b1, 1'b1, 128'hBEEF, 1'b1);
    check("full_sim_cnt15", {bus.o_full, bus.o_alm_full}, 2'b01);
    for (int i = 0; i < 15; i++) rd();

    // Simultaneous at empty: only the write lands, no fall-through.
    last = bus.o_rddata;
    step(1'b1, 1'b1, 128'h1234, 1'b1);
    check("empty_sim_hold", bus.o_rddata, last);
    check("empty_sim_cnt1", bus.o_empty, 1'b0);
    rd();
    check("empty_sim_data", bus.o_rddata, 128'h1234);

    // Random traffic with occasional mid-stream reset.
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 300) % 3;
      if ($urandom_range(0, 199) == 0)
        step(1'b0, $urandom_range(0, 1) == 1, rnd_word(), $urandom_range(0, 1) == 1);
      else if (mode == 0)
        step(1'b1, $urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 3) == 0);
      else if (mode == 1)
        step(1'b1, $urandom_range(0, 3) == 0, rnd_word(), $urandom_range(0, 3) != 0);
      else
        step(1'b1, $urandom_range(0, 1) == 1, rnd_word(), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
